// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus a shift-add
// multiplier, with a valid/ready handshake on both the request and result sides.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       FLAGS
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] ALU_OP_ADD  = 4'h0;
    localparam logic [3:0] ALU_OP_SUB  = 4'h1;
    localparam logic [3:0] ALU_OP_AND  = 4'h2;
    localparam logic [3:0] ALU_OP_OR   = 4'h3;
    localparam logic [3:0] ALU_OP_XOR  = 4'h4;
    localparam logic [3:0] ALU_OP_NOT  = 4'h5;
    localparam logic [3:0] ALU_OP_SLL  = 4'h6;
    localparam logic [3:0] ALU_OP_SRL  = 4'h7;
    localparam logic [3:0] ALU_OP_SRA  = 4'h8;
    localparam logic [3:0] ALU_OP_SLT  = 4'h9;
    localparam logic [3:0] ALU_OP_SLTU = 4'hA;
    localparam logic [3:0] ALU_OP_MUL  = 4'hB;

    localparam int ALU_FLAG_Z = 0;
    localparam int ALU_FLAG_N = 1;
    localparam int ALU_FLAG_C = 2;
    localparam int ALU_FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_step_acc;
    logic [3:0]       w_mul_flags;

    assign in_ready  = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign Y         = r_y;
    assign FLAGS     = r_flags;

    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = B[SHW-1:0];

    // Single-cycle result and flags for the operation on the request inputs.
    always_comb begin
        w_res   = {WIDTH{1'b0}};
        w_flags = 4'b0000;
        case (alu_op)
            ALU_OP_ADD: begin
                w_res               = w_sum[WIDTH-1:0];
                w_flags[ALU_FLAG_C] = w_sum[WIDTH];
                w_flags[ALU_FLAG_V] = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                w_res               = w_diff[WIDTH-1:0];
                w_flags[ALU_FLAG_C] = w_diff[WIDTH];
                w_flags[ALU_FLAG_V] = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_OP_AND:  w_res = A & B;
            ALU_OP_OR:   w_res = A | B;
            ALU_OP_XOR:  w_res = A ^ B;
            ALU_OP_NOT:  w_res = ~(A | B);
            ALU_OP_SLL:  w_res = A << w_shamt;
            ALU_OP_SRL:  w_res = A >> w_shamt;
            ALU_OP_SRA:  w_res = $signed(A) >>> w_shamt;
            ALU_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default:     w_res = {WIDTH{1'b0}};
        endcase
        w_flags[ALU_FLAG_Z] = (w_res == {WIDTH{1'b0}});
        w_flags[ALU_FLAG_N] = w_res[WIDTH-1];
    end

    // One shift-add step of the multiplier and the flags of its running product.
    always_comb begin
        w_step_acc  = r_acc + ({WIDTH{r_mplier[0]}} & r_mcand);
        w_mul_flags = 4'b0000;
        w_mul_flags[ALU_FLAG_Z] = (w_step_acc == {WIDTH{1'b0}});
        w_mul_flags[ALU_FLAG_N] = w_step_acc[WIDTH-1];
    end

    // Control FSM with registered result, flags and multiplier state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_y         <= {WIDTH{1'b0}};
            r_flags     <= 4'b0000;
            r_mcand     <= {WIDTH{1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_cnt       <= {SHW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (alu_op == ALU_OP_MUL)) begin
                        // The accept edge already performs the step for B[0].
                        r_acc       <= {WIDTH{B[0]}} & A;
                        r_mcand     <= A << 1;
                        r_mplier    <= B >> 1;
                        r_cnt       <= SHW'(WIDTH - 1);
                        r_out_valid <= 1'b0;
                        r_state     <= MUL;
                    end else if (w_accept) begin
                        r_y         <= w_res;
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end else if (r_out_valid) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MUL: begin
                    r_acc    <= w_step_acc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_y         <= w_step_acc;
                        r_flags     <= w_mul_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= MUL;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are 8 to 64, and even values only.
REQ-002 SHALL have derived localparam SHW = clog2(WIDTH), the number of shift-amount bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port A, input, WIDTH bits: operand A.
REQ-008 SHALL have port B, input, WIDTH bits: operand B, or the shift amount.
REQ-009 SHALL have port alu_op, input, 4 bits: the opcode (ALU_OP_* codes), plus ALU_OP_MUL = 4'hB.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port Y, output, WIDTH bits: the registered result.
REQ-013 SHALL have port FLAGS, output, 4 bits: registered Z/N/C/V at the ALU_FLAG_* bit indices.

Function
REQ-014 SHALL implement FSM states IDLE, MUL and HOLD; the state after reset is IDLE.
REQ-015 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-016 SHALL accept a request on any edge where in_valid && in_ready; A, B and alu_op are captured at that edge.
REQ-017 SHALL register the result of a non-MUL op on the accept edge: out_valid=1 in the next cycle (latency 1), and the state stays IDLE.
REQ-018 SHALL sustain a throughput of 1 non-MUL op per cycle while out_ready=1.
REQ-019 SHALL implement the ops as follows: ADD A+B; SUB A-B; AND; OR; XOR; NOT = ~(A|B); SLL/SRL/SRA by B[SHW-1:0]; SLT signed A<B -> 1 else 0; SLTU unsigned A<B -> 1 else 0.
REQ-020 SHALL, for MUL: load the multiplicand, the multiplier and an iteration counter of WIDTH-1 on accept, then enter the MUL state.
REQ-021 SHALL, in the MUL state, perform one shift-add step per cycle and take WIDTH edges in total from accept.
REQ-022 SHALL, on the final MUL edge: write the low WIDTH bits of A*B to Y, set out_valid=1, and return to IDLE; the MUL latency is WIDTH cycles.
REQ-023 SHALL keep in_ready=0 for the whole MUL state.
REQ-024 SHALL compute FLAGS as follows:
 - Z = (Y==0)
 - N = Y[WIDTH-1]
 - C = carry-out of A+B for ADD, and carry-out of A+~B+1 for SUB (no-borrow semantics; 3-4 gives C=0)
 - V = signed overflow for ADD/SUB
 - C=V=0 for all other ops.
REQ-025 SHALL treat opcodes 4'hC..4'hF as illegal: Y=0, FLAGS=Z only, latency 1, with no error lockup.
REQ-026 SHALL, when out_valid=1 and out_ready=0, hold Y and FLAGS stable (state HOLD) and keep in_ready=0.
REQ-027 SHALL, on an edge with out_valid && out_ready and no new accept, clear out_valid.
REQ-028 SHALL, on an edge with out_valid && out_ready && accept of a non-MUL op, load the new result with out_valid remaining 1.
REQ-029 SHALL, on an edge with out_valid && out_ready && accept of MUL, clear out_valid until the MUL completes.
REQ-030 SHALL ignore in_valid changes when in_ready=0; no request is dropped or duplicated.

Reset
REQ-031 SHALL, when rst=1 asynchronously, set: state=IDLE, out_valid=0, Y=0, FLAGS=0, counter=0, and all MUL registers 0.
REQ-032 SHALL, when rst asserts mid-MUL, abort the MUL; no result is ever presented for it.
REQ-033 SHALL keep in_ready low while rst=1, and allow it high from the first cycle after rst deasserts.

Verification
REQ-034 SHALL cover, at WIDTH=32: ADD 0x7FFFFFFF+1 -> Y=0x80000000, N=1, V=1, C=0; SUB 3-4 -> Y=0xFFFFFFFF, N=1, C=0, V=0.
REQ-035 SHALL cover, at WIDTH=32: MUL 0x00010001*0x00010001 -> out_valid exactly 32 cycles after accept, Y=0x00020001, in_ready=0 throughout.
REQ-036 SHALL cover, at WIDTH=8: SRA 0x80 by 1 -> 0xC0, N=1; SLT 0xFF vs 0x01 -> 1; SLTU 0xFF vs 0x01 -> 0, Z=1; MUL 0x10*0x10 -> 0x00, Z=1, latency 8.
REQ-037 SHALL cover backpressure: hold out_ready=0 for 5 cycles after an ADD result -> Y/FLAGS stable and in_ready=0; then with out_ready=1 -> a back-to-back stream of 4 ops, 1 result per cycle, in order.
REQ-038 SHALL cover reset mid-operation: assert rst 10 cycles into a MUL -> out_valid=0 and Y=0 immediately; after release, an ADD 1+2 -> Y=3 with latency 1.
REQ-039 SHALL cover illegal op 4'hE -> Y=0, FLAGS=Z only; the next ADD is accepted normally.
